// File: rtl/io_bitbang_sync_if.sv
// rtl/io_bitbang_sync_if.sv - controller-side register bundle for io_bitbang_sync (IO_BITBANG_OPEN_DRAIN_EN adds in_io_opendrain)
interface io_bitbang_sync_if #(
  parameter int IO_NUM_OF = 10
);
  logic [IO_NUM_OF-1:0] in_io_direction;
  logic [IO_NUM_OF-1:0] in_io_outval;
  logic [IO_NUM_OF-1:0] in_io_irq_mask;
  logic [IO_NUM_OF-1:0] in_io_edge_clr;
`ifdef IO_BITBANG_OPEN_DRAIN_EN
  logic [IO_NUM_OF-1:0] in_io_opendrain;
`endif
  logic [IO_NUM_OF-1:0] out_io_inputval;
  logic [IO_NUM_OF-1:0] out_io_rise;
  logic [IO_NUM_OF-1:0] out_io_fall;
  logic                 out_io_irq;

`ifdef IO_BITBANG_OPEN_DRAIN_EN
  modport master (
    output in_io_direction, in_io_outval, in_io_irq_mask, in_io_edge_clr, in_io_opendrain,
    input  out_io_inputval, out_io_rise, out_io_fall, out_io_irq
  );
  modport slave (
    input  in_io_direction, in_io_outval, in_io_irq_mask, in_io_edge_clr, in_io_opendrain,
    output out_io_inputval, out_io_rise, out_io_fall, out_io_irq
  );
`else
  modport master (
    output in_io_direction, in_io_outval, in_io_irq_mask, in_io_edge_clr,
    input  out_io_inputval, out_io_rise, out_io_fall, out_io_irq
  );
  modport slave (
    input  in_io_direction, in_io_outval, in_io_irq_mask, in_io_edge_clr,
    output out_io_inputval, out_io_rise, out_io_fall, out_io_irq
  );
`endif
endinterface

// File: rtl/io_bitbang_sync.sv
// rtl/io_bitbang_sync.sv - registered tri-state pin driver with synchronised, glitch-filtered inputs and sticky edge flags
// Optional open-drain pins: define IO_BITBANG_OPEN_DRAIN_EN.
module io_bitbang_sync #(
  parameter int IO_NUM_OF   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  io_bitbang_sync_if.slave     bus,
  inout  wire  [IO_NUM_OF-1:0] io_pins
);
  localparam int CNT_W = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILTER_LEN > 0) ? FILTER_LEN - 1 : 0);

  logic [IO_NUM_OF-1:0]                  dir_q, outval_q;
  logic [IO_NUM_OF-1:0]                  drive_en, drive_val;
  logic [SYNC_STAGES-1:0][IO_NUM_OF-1:0] sync_q;
  logic [IO_NUM_OF-1:0]                  synced;
  logic [IO_NUM_OF-1:0]                  stable_q, stable_nxt;
  logic [IO_NUM_OF-1:0][CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [IO_NUM_OF-1:0]                  rise_q, fall_q;

`ifdef IO_BITBANG_OPEN_DRAIN_EN
  logic [IO_NUM_OF-1:0] od_q;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) od_q <= '0;
    else          od_q <= bus.in_io_opendrain;
  end

  // Open-drain pins only ever pull low; a high level is left to the external pull-up.
  assign drive_en  = dir_q & (~od_q | ~outval_q);
  assign drive_val = outval_q & ~od_q;
`else
  assign drive_en  = dir_q;
  assign drive_val = outval_q;
`endif

  for (genvar i = 0; i < IO_NUM_OF; i++) begin : g_pin
    assign io_pins[i] = drive_en[i] ? drive_val[i] : 1'bz;
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_nxt = stable_q;
    cnt_nxt    = cnt_q;
    for (int i = 0; i < IO_NUM_OF; i++) begin
      if (FILTER_LEN == 0) begin
        stable_nxt[i] = synced[i];
        cnt_nxt[i]    = '0;
      end else if (synced[i] == stable_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_nxt[i] = synced[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A new edge is OR-ed in after the clear so an event coincident with a clear survives.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      dir_q    <= '0;
      outval_q <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      dir_q    <= bus.in_io_direction;
      outval_q <= bus.in_io_outval;
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], io_pins};
      else                 sync_q <= io_pins;
      stable_q <= stable_nxt;
      cnt_q    <= cnt_nxt;
      rise_q   <= (rise_q & ~bus.in_io_edge_clr) | (stable_nxt & ~stable_q);
      fall_q   <= (fall_q & ~bus.in_io_edge_clr) | (~stable_nxt & stable_q);
    end
  end

  assign bus.out_io_inputval = stable_q;
  assign bus.out_io_rise     = rise_q;
  assign bus.out_io_fall     = fall_q;
  assign bus.out_io_irq      = |((rise_q | fall_q) & bus.in_io_irq_mask);
endmodule

// File: tb/tb_io_bitbang_sync.sv
// tb/tb_io_bitbang_sync.sv - directed table-driven bench for io_bitbang_sync (default and unfiltered instances)
module tb_io_bitbang_sync;
  logic clk;
  logic rst;
  wire  [9:0] pins_a;
  wire  [9:0] pins_b;
  logic [9:0] ext_a_oe, ext_a_val, ext_b_oe, ext_b_val;
  int checks;
  int failures;

  io_bitbang_sync_if #(.IO_NUM_OF(10)) bus_a ();
  io_bitbang_sync_if #(.IO_NUM_OF(10)) bus_b ();

  io_bitbang_sync #(.IO_NUM_OF(10), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_a (
    .in_clk(clk), .in_reset(rst), .bus(bus_a), .io_pins(pins_a)
  );
  io_bitbang_sync #(.IO_NUM_OF(10), .SYNC_STAGES(3), .FILTER_LEN(0)) dut_b (
    .in_clk(clk), .in_reset(rst), .bus(bus_b), .io_pins(pins_b)
  );

  for (genvar i = 0; i < 10; i++) begin : g_ext
    pulldown (pins_a[i]);
    pulldown (pins_b[i]);
    assign pins_a[i] = ext_a_oe[i] ? ext_a_val[i] : 1'bz;
    assign pins_b[i] = ext_b_oe[i] ? ext_b_val[i] : 1'bz;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0] dir, outval, mask, clr, eoe, ev;
    int         cycles;
    logic [9:0] e_in, e_rise, e_fall;
    logic       e_irq;
    string      name;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [9:0] e_in, input logic [9:0] e_r,
                         input logic [9:0] e_f, input logic e_irq);
    check({tag, "_inputval"}, 32'(bus_a.out_io_inputval), 32'(e_in));
    check({tag, "_rise"},     32'(bus_a.out_io_rise),     32'(e_r));
    check({tag, "_fall"},     32'(bus_a.out_io_fall),     32'(e_f));
    check({tag, "_irq"},      32'(bus_a.out_io_irq),      32'(e_irq));
  endtask

  initial begin
    checks = 0; failures = 0;
    ext_a_oe = '0; ext_a_val = '0; ext_b_oe = '0; ext_b_val = '0;
    bus_a.in_io_direction = '0; bus_a.in_io_outval = '0; bus_a.in_io_irq_mask = '0; bus_a.in_io_edge_clr = '0;
    bus_b.in_io_direction = '0; bus_b.in_io_outval = '0; bus_b.in_io_irq_mask = '0; bus_b.in_io_edge_clr = '0;
`ifdef IO_BITBANG_OPEN_DRAIN_EN
    bus_a.in_io_opendrain = '0; bus_b.in_io_opendrain = '0;
`endif
    //           dir     outval  mask    clr     eoe     ev      cyc in      rise    fall    irq
    tbl[0]  = '{10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h001, 10'h001, 10'h000, 1'b0, "mask_off"};
    tbl[1]  = '{10'h001, 10'h001, 10'h002, 10'h000, 10'h000, 10'h000, 1, 10'h001, 10'h001, 10'h000, 1'b0, "mask_other"};
    tbl[2]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 1, 10'h001, 10'h001, 10'h000, 1'b1, "mask_hit"};
    tbl[3]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h004, 3, 10'h001, 10'h001, 10'h000, 1'b1, "glitch3_hi"};
    tbl[4]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h000, 8, 10'h001, 10'h001, 10'h000, 1'b1, "glitch3_lo"};
    tbl[5]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h004, 4, 10'h001, 10'h001, 10'h000, 1'b1, "pulse4_hi"};
    tbl[6]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h000, 2, 10'h005, 10'h005, 10'h000, 1'b1, "pulse4_acc"};
    tbl[7]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h000, 4, 10'h001, 10'h005, 10'h004, 1'b1, "pulse4_rel"};
    tbl[8]  = '{10'h001, 10'h001, 10'h001, 10'h001, 10'h004, 10'h000, 1, 10'h001, 10'h004, 10'h004, 1'b0, "clr0"};
    tbl[9]  = '{10'h001, 10'h001, 10'h001, 10'h000, 10'h004, 10'h000, 1, 10'h001, 10'h004, 10'h004, 1'b0, "clr0_idle"};
    tbl[10] = '{10'h001, 10'h001, 10'h004, 10'h000, 10'h004, 10'h000, 1, 10'h001, 10'h004, 10'h004, 1'b1, "mask2"};
    tbl[11] = '{10'h001, 10'h001, 10'h004, 10'h004, 10'h004, 10'h000, 1, 10'h001, 10'h000, 10'h000, 1'b0, "clr2"};
    tbl[12] = '{10'h001, 10'h001, 10'h004, 10'h000, 10'h004, 10'h000, 1, 10'h001, 10'h000, 10'h000, 1'b0, "clr2_idle"};
    tbl[13] = '{10'h001, 10'h000, 10'h001, 10'h000, 10'h004, 10'h000, 6, 10'h001, 10'h000, 10'h000, 1'b0, "fall_wait"};
    tbl[14] = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h004, 10'h000, 1, 10'h000, 10'h000, 10'h001, 1'b1, "fall_vs_clr"};
    tbl[15] = '{10'h001, 10'h000, 10'h001, 10'h000, 10'h004, 10'h000, 1, 10'h000, 10'h000, 10'h001, 1'b1, "fall_held"};

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check_a("reset", 10'h000, 10'h000, 10'h000, 1'b0);
    check("reset_pins", 32'(pins_a), 32'h0);
    step(1);
    check_a("reset_idle", 10'h000, 10'h000, 10'h000, 1'b0);

    // Loopback of pin 0: pin after 1 edge, filtered level after 1+2+4 edges.
    bus_a.in_io_direction = 10'h001; bus_a.in_io_outval = 10'h001;
    step(1);
    check("loop_pin0", 32'(pins_a[0]), 32'h1);
    check("loop_inputval_early", 32'(bus_a.out_io_inputval), 32'h0);
    step(5);
    check("loop_inputval_edge6", 32'(bus_a.out_io_inputval), 32'h0);
    step(1);
    check_a("loop_edge7", 10'h001, 10'h001, 10'h000, 1'b0);

    for (int k = 0; k < 16; k++) begin
      bus_a.in_io_direction = tbl[k].dir;
      bus_a.in_io_outval    = tbl[k].outval;
      bus_a.in_io_irq_mask  = tbl[k].mask;
      bus_a.in_io_edge_clr  = tbl[k].clr;
      ext_a_oe              = tbl[k].eoe;
      ext_a_val             = tbl[k].ev;
      step(tbl[k].cycles);
      check_a(tbl[k].name, tbl[k].e_in, tbl[k].e_rise, tbl[k].e_fall, tbl[k].e_irq);
    end
    bus_a.in_io_edge_clr = '0;
    ext_a_oe = '0;

    // Unfiltered instance: 3 sync stages then one edge into the stable register.
    ext_b_oe = 10'h008; ext_b_val = 10'h008;
    step(3);
    check("b_rise_edge3", 32'(bus_b.out_io_inputval), 32'h0);
    step(1);
    check("b_rise_edge4", 32'(bus_b.out_io_inputval), 32'h008);
    check("b_rise_flag", 32'(bus_b.out_io_rise), 32'h008);
    ext_b_val = 10'h000;
    step(4);
    check("b_fall_val", 32'(bus_b.out_io_inputval), 32'h0);
    check("b_fall_flag", 32'(bus_b.out_io_fall), 32'h008);
    bus_b.in_io_edge_clr = 10'h008;
    step(1);
    bus_b.in_io_edge_clr = '0;
    check("b_clr", 32'({bus_b.out_io_rise, bus_b.out_io_fall}), 32'h0);
    ext_b_val = 10'h008;
    step(1);
    ext_b_val = 10'h000;
    step(6);
    check("b_pulse_val", 32'(bus_b.out_io_inputval), 32'h0);
    check("b_pulse_rise", 32'(bus_b.out_io_rise), 32'h008);
    check("b_pulse_fall", 32'(bus_b.out_io_fall), 32'h008);

`ifdef IO_BITBANG_OPEN_DRAIN_EN
    bus_a.in_io_opendrain = 10'h001; bus_a.in_io_direction = 10'h001; bus_a.in_io_outval = 10'h000;
    step(2);
    check("od_low", 32'(pins_a[0]), 32'h0);
    bus_a.in_io_outval = 10'h001; ext_a_oe = 10'h001; ext_a_val = 10'h001;
    step(2);
    check("od_release", 32'(pins_a[0]), 32'h1);
    bus_a.in_io_opendrain = '0; ext_a_oe = '0; ext_a_val = '0;
`endif

    // Drive every pin high, then reset mid-cycle: pins must release at once.
    bus_a.in_io_direction = 10'h3ff; bus_a.in_io_outval = 10'h3ff;
    step(1);
    check("all_drive_pins", 32'(pins_a), 32'h3ff);
    step(7);
    check("all_drive_inputval", 32'(bus_a.out_io_inputval), 32'h3ff);
    #3 rst = 1'b1;
    #1;
    check("midrst_pins", 32'(pins_a), 32'h0);
    check_a("midrst", 10'h000, 10'h000, 10'h000, 1'b0);
    bus_a.in_io_direction = '0; bus_a.in_io_outval = '0;
    step(2);
    rst = 1'b0;
    step(1);
    check_a("post_rst", 10'h000, 10'h000, 10'h000, 1'b0);
    check("post_rst_pins", 32'(pins_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
